// File: rtl/sorted_insert_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sorted_insert_pkg
// Description : Shared types and defaults for the sorted insertion buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package sorted_insert_pkg;

  localparam int c_default_w = 8;
  localparam int c_default_n = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to hold an entry count in the range 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sorted_dup_det.sv
`default_nettype none
// ============================================================================
// Module      : sorted_dup_det
// Description : N-way key equality check over the valid lanes of the table.
//               Compiled only when SORTED_INSERT_DEDUP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef SORTED_INSERT_DEDUP_EN
module sorted_dup_det
  import sorted_insert_pkg::*;
#(
  parameter int W  = c_default_w,
  parameter int N  = c_default_n,
  parameter int CW = cnt_width(N)
) (
  input  logic [N*W-1:0] data,
  input  logic [CW-1:0]  count,
  input  logic [W-1:0]   key,
  output logic           hit
);

  logic [N-1:0] w_match;

  for (genvar i = 0; i < N; i++) begin : g_lane_cmp
    assign w_match[i] = (CW'(i) < count) && (data[i*W +: W] == key);
  end

  assign hit = |w_match;

endmodule
`endif
`default_nettype wire

// File: rtl/sorted_insert_buf.sv
`default_nettype none
// ============================================================================
// Module      : sorted_insert_buf
// Description : Descending-sorted key table built by one-step-per-cycle
//               insertion sort. Optional duplicate rejection is enabled by
//               defining SORTED_INSERT_DEDUP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sorted_insert_buf
  import sorted_insert_pkg::*;
#(
  parameter int W = c_default_w,
  parameter int N = c_default_n,
  localparam int CW = cnt_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [W-1:0]   din,
  input  logic           clr,
  output logic           rdy,
  output logic [N*W-1:0] data,
  output logic [CW-1:0]  count,
  output logic           full,
  output logic           done,
  output logic           drop
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_lane [N];
  logic [W-1:0]  r_key;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] r_count;
  logic          r_done;
  logic          r_drop;

  logic          w_full;
  logic          w_dup;
  logic [W-1:0]  w_prev;
  logic          w_move;
  logic          w_accept;
  logic          w_reject;
  logic          w_shift;
  logic          w_place;
  logic [N*W-1:0] w_data;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign w_data[i*W +: W] = r_lane[i];
  end

  assign w_full = (r_count == CW'(N));

`ifdef SORTED_INSERT_DEDUP_EN
  sorted_dup_det #(
    .W  (W),
    .N  (N),
    .CW (CW)
  ) u_dup_det (
    .data  (w_data),
    .count (r_count),
    .key   (din),
    .hit   (w_dup)
  );
`else
  assign w_dup = 1'b0;
`endif

  // Lane just above the insertion point; ties stop the shift so arrival order holds.
  always_comb begin
    w_prev = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (r_pos == CW'(i + 1)) begin
        w_prev = r_lane[i];
      end
    end
  end

  assign w_move = (r_pos != '0) && (w_prev < r_key);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_shift     = 1'b0;
    w_place     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          if (w_dup || w_full) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (w_move) begin
          w_shift = 1'b1;
        end else begin
          w_place     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clr) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      w_shift     = 1'b0;
      w_place     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < N; i++) begin
        r_lane[i] <= '0;
      end
      r_key   <= '0;
      r_pos   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_done <= w_place;
      r_drop <= w_reject;
      if (w_accept) begin
        r_key <= din;
        r_pos <= r_count;
      end
      if (w_shift) begin
        for (int i = 0; i < N; i++) begin
          if (r_pos == CW'(i)) begin
            r_lane[i] <= w_prev;
          end
        end
        r_pos <= r_pos - CW'(1);
      end
      if (w_place) begin
        for (int i = 0; i < N; i++) begin
          if (r_pos == CW'(i)) begin
            r_lane[i] <= r_key;
          end
        end
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign rdy   = (r_state == IDLE);
  assign data  = w_data;
  assign count = r_count;
  assign full  = w_full;
  assign done  = r_done;
  assign drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sorted_insert_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sorted_insert_buf
// Description : Directed vector bench for sorted_insert_buf (W=8, N=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sorted_insert_buf;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  din;
  logic        clr;
  logic        rdy;
  logic [63:0] data;
  logic [3:0]  count;
  logic        full;
  logic        done;
  logic        drop;

  int checks;
  int errors;

  sorted_insert_buf #(.W(8), .N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .din   (din),
    .clr   (clr),
    .rdy   (rdy),
    .data  (data),
    .count (count),
    .full  (full),
    .done  (done),
    .drop  (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          clr_first;
    logic [7:0]  din;
    int          lat;
    logic [63:0] data;
    int          cnt;
    bit          full;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  // Latency counts cycles from the accept cycle to the cycle where done is high.
  task automatic do_insert(input logic [7:0] d, output int lat);
    @(negedge clk);
    en  = 1'b1;
    din = d;
    @(posedge clk);
    #1 en = 1'b0;
    lat = 0;
    repeat (20) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  int lat;
  bit saw_done;
  bit saw_drop;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    din    = '0;
    clr    = 1'b0;

    vecs[0]  = '{1'b1, 8'h05, 2, 64'h05, 1, 1'b0};
    vecs[1]  = '{1'b0, 8'h09, 3, 64'h0509, 2, 1'b0};
    vecs[2]  = '{1'b0, 8'h01, 2, 64'h010509, 3, 1'b0};
`ifdef SORTED_INSERT_DEDUP_EN
    vecs[3]  = '{1'b0, 8'h07, 4, 64'h01050709, 4, 1'b0};
`else
    vecs[3]  = '{1'b0, 8'h09, 4, 64'h01050909, 4, 1'b0};
`endif
    vecs[4]  = '{1'b1, 8'h10, 2, 64'h10, 1, 1'b0};
    vecs[5]  = '{1'b0, 8'h11, 3, 64'h1011, 2, 1'b0};
    vecs[6]  = '{1'b0, 8'h12, 4, 64'h101112, 3, 1'b0};
    vecs[7]  = '{1'b0, 8'h13, 5, 64'h10111213, 4, 1'b0};
    vecs[8]  = '{1'b0, 8'h14, 6, 64'h1011121314, 5, 1'b0};
    vecs[9]  = '{1'b0, 8'h15, 7, 64'h101112131415, 6, 1'b0};
    vecs[10] = '{1'b0, 8'h16, 8, 64'h10111213141516, 7, 1'b0};
    vecs[11] = '{1'b0, 8'h17, 9, 64'h1011121314151617, 8, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset data",  data,  64'h0);
    check("reset count", count, 64'h0);
    check("reset rdy",   rdy,   64'h1);
    check("reset full",  full,  64'h0);
    check("reset done",  done,  64'h0);
    check("reset drop",  drop,  64'h0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].clr_first) pulse_clr();
      do_insert(vecs[i].din, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d data", i),  data,  vecs[i].data);
      check($sformatf("vec%0d count", i), count, 64'(vecs[i].cnt));
      check($sformatf("vec%0d full", i),  full,  64'(vecs[i].full));
      check($sformatf("vec%0d rdy", i),   rdy,   64'h1);
    end

    // Insert into a full table is rejected with a one-cycle drop.
    @(negedge clk);
    en  = 1'b1;
    din = 8'h20;
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    check("full drop",      drop, 64'h1);
    check("full no done",   done, 64'h0);
    check("full rdy",       rdy,  64'h1);
    check("full data kept", data, 64'h1011121314151617);
    @(negedge clk);
    check("full drop ends", drop, 64'h0);
    check("full count",     count, 64'h8);

    // Clear in the middle of a 4-step shift.
    pulse_clr();
    for (int i = 1; i <= 4; i++) do_insert(8'(i), lat);
    check("pre-clr data", data, 64'h01020304);
    @(negedge clk);
    en  = 1'b1;
    din = 8'h50;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-shift rdy", rdy, 64'h0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("clr data",  data,  64'h0);
    check("clr count", count, 64'h0);
    check("clr rdy",   rdy,   64'h1);
    saw_done = done;
    repeat (6) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("clr no done", 64'(saw_done), 64'h0);

    // Reset during SHIFT.
    do_insert(8'h01, lat);
    do_insert(8'h02, lat);
    @(negedge clk);
    en  = 1'b1;
    din = 8'h03;
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst data",  data,  64'h0);
    check("rst count", count, 64'h0);
    check("rst rdy",   rdy,   64'h1);
    check("rst full",  full,  64'h0);
    check("rst done",  done,  64'h0);
    check("rst drop",  drop,  64'h0);
    rst_n = 1'b1;
    do_insert(8'h7F, lat);
    check("post-rst lane0", data, 64'h7F);
    check("post-rst count", count, 64'h1);

    // en held while busy is ignored.
    @(negedge clk);
    en  = 1'b1;
    din = 8'h80;
    @(posedge clk);
    #1 din = 8'hAA;
    saw_done = 1'b0;
    saw_drop = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_drop = saw_drop | drop;
      if (done) begin
        en = 1'b0;
        saw_done = 1'b1;
        break;
      end
    end
    check("busy en done", 64'(saw_done), 64'h1);
    check("busy en drop", 64'(saw_drop), 64'h0);
    check("busy en data", data,  64'h7F80);
    check("busy en count", count, 64'h2);
    repeat (3) @(negedge clk);
    check("busy en later data", data, 64'h7F80);

    // Duplicate key handling.
    pulse_clr();
    do_insert(8'h03, lat);
    check("dup first lat", 64'(lat), 64'h2);
    @(negedge clk);
    en  = 1'b1;
    din = 8'h03;
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
`ifdef SORTED_INSERT_DEDUP_EN
    check("dup drop",  drop,  64'h1);
    check("dup done",  done,  64'h0);
    @(negedge clk);
    check("dup count", count, 64'h1);
    check("dup data",  data,  64'h03);
`else
    check("dup no drop", drop, 64'h0);
    saw_done = done;
    repeat (5) begin
      if (!saw_done) begin
        @(negedge clk);
        saw_done = done;
      end
    end
    check("dup done",  64'(saw_done), 64'h1);
    check("dup count", count, 64'h2);
    check("dup data",  data,  64'h0303);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // done and drop must never overlap.
  always @(negedge clk) begin
    if (rst_n && done && drop) begin
      checks++;
      errors++;
      $display("FAIL done/drop overlap: got done=%b drop=%b required not both", done, drop);
    end
  end

endmodule
`default_nettype wire
